seg7_mux_display: RTL and testbench
===================================

Name: seg7_mux_display

Overview:
Parametrised, time-multiplexed hex driver for a NUM_DIGITS common-anode 7-segment bank.
- Accepts a packed word of NUM_DIGITS nibbles with a valid strobe, double-buffers it and commits at frame boundaries, so no digit ever shows a mix of old and new data.
- Scans one digit per slot, with a guard interval against ghosting, optional leading-zero suppression, per-digit decimal points and a global blank.
- Sits between the MIDI status/data logic and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8).
REFRESH_DIV, 50000, clk cycles per digit slot (>= GUARD_CYCLES+2).
GUARD_CYCLES, 2, cycles at slot start with all anodes off.
LZ_SUPPRESS, 1, 1 = blank leading zero digits (digit 0 never blanked).
SEG_ACTIVE_LOW, 1, 1 = segment bit 0 lights the segment.
AN_ACTIVE_LOW, 1, 1 = anode bit 0 enables the digit.

Ports:
clk  in  1  system clock, single clock domain.
reset  in  1  synchronous, active-high reset.
data_in  in  4*NUM_DIGITS  nibble k = digit k, digit 0 = rightmost.
valid_in  in  1  capture data_in this cycle.
dp_in  in  NUM_DIGITS  decimal point per digit, captured with data_in.
blank_in  in  1  level; force the display dark.
segments_out  out  7  {g,f,e,d,c,b,a}, registered.
dp_out  out  1  decimal point for the active digit, registered.
anode_out  out  NUM_DIGITS  one-hot digit enable, registered.
commit_out  out  1  one-cycle pulse when pending data becomes displayed.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset (sampled on a clk edge):
  - slot counter = 0, digit index = 0.
  - pending and displayed registers = 0; pending flag = 0.
  - commit_out = 0.
  - anodes all off, segments all off, dp off (polarity per parameters; 7'b1111111 when active-low).
- Reset mid-frame: the same values apply at the next edge. Data accepted earlier is discarded.
- Capture:
  - On valid_in=1, data_in and dp_in load the pending register and the pending flag sets.
  - Last write in a frame wins.
- Frame end: cnt==REFRESH_DIV-1 and idx==NUM_DIGITS-1.
  - If the pending flag is set, pending loads into displayed, the flag clears, and commit_out pulses for exactly that cycle.
  - If valid_in=1 on the frame-end cycle, the current data_in commits directly (bypass), commit_out pulses and the flag stays clear.
- Slot sequencing (per-slot FSM):
  - GUARD: cnt < GUARD_CYCLES.
  - ON: cnt >= GUARD_CYCLES.
  - cnt counts 0..REFRESH_DIV-1. On wrap, idx increments modulo NUM_DIGITS.
- Output path:
  - Outputs are registered one cycle after the cnt/idx state they reflect.
  - GUARD: anodes all off, segments all off.
  - ON: anode[idx] on; segments = decode(displayed nibble idx); dp_out = displayed dp[idx].
- Decode table (active-low, bit order gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, b=0000011, c=0100111, d=0100001, E=0000110, F=0001110
  - When SEG_ACTIVE_LOW=0, the value is inverted.
- Leading-zero suppression (LZ_SUPPRESS=1):
  - Digit k>0 is suppressed when nibbles k..NUM_DIGITS-1 are all zero and its dp is 0.
  - A suppressed digit drives anode off and segments off during its ON phase.
- blank_in=1: anodes off from the next registered output. The counter, idx, capture and commit continue unaffected.
- NUM_DIGITS=1: idx is constant 0; frame end = slot end.

Decomposition:
- Package seg7_pkg:
  - function hex_to_seg (4-bit to 7-bit active-low, table above).
  - constant SEG_OFF_AL = 7'b1111111.
  - typedef slot_state_t {GUARD, ON}.
- Sub-module seg7_hex_lut: combinational wrapper around hex_to_seg.
- The scan FSM, buffering and LZ logic stay in the top module.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2, all active-low, LZ on):
- Reset pulse for 3 cycles -> anode_out=4'b1111 and segments_out=7'b1111111 throughout reset. First ON slot after release: anode_out=4'b1110, segments=1000000 (LZ on a zero value).
- valid_in with 16'h12A0 mid-frame -> the old value stays displayed until frame end; one commit_out pulse. Next frame:
  - digit0 = 1000000
  - digit1 = 0001000
  - digit2 = 0100100
  - digit3 = 1111001
- 16'h0005 committed -> digit0 = 0010010 with anode 1110. Slots 1-3 keep anodes 1111 and segments 1111111.
- valid_in 16'h1111 then 16'h2222 in the same frame -> a single commit_out pulse; all digits = 0100100.
- valid_in 16'h0F00 exactly on the frame-end cycle -> commit_out that cycle. Next frame: digit2 = 0001110, digit3 blank.
- blank_in held for one frame -> anode_out=4'b1111 for the whole frame. idx sequence and commit timing are identical to an unblanked run.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment table for the multiplexed 7-segment driver.
// The table is stored active-low in {g,f,e,d,c,b,a} order.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF_AL = 7'b1111111;

    typedef enum logic {GUARD, ON} slot_state_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0011000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b0100111;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_hex_lut.sv
// Combinational nibble-to-segment decoder (active-low pattern).
module seg7_hex_lut
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_mux_display.sv
// Time-multiplexed hex display driver: double-buffered digits committed at frame end,
// per-slot guard interval, leading-zero suppression, decimal points and global blank.
module seg7_mux_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int GUARD_CYCLES   = 2,
    parameter bit LZ_SUPPRESS    = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic                    valid_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_in,
    output logic [6:0]              segments_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   anode_out,
    output logic                    commit_out
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam slot_state_t RESET_STATE = (GUARD_CYCLES > 0) ? GUARD : ON;
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? SEG_OFF_AL : 7'b0000000;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic DP_OFF = SEG_ACTIVE_LOW;

    logic [CNT_W-1:0]        cnt_p0, cnt_next;
    logic [IDX_W-1:0]        idx_p0, idx_next;
    slot_state_t             state_p0, state_next;
    logic                    frame_end;

    logic [4*NUM_DIGITS-1:0] pend_data, disp_data;
    logic [NUM_DIGITS-1:0]   pend_dp, disp_dp;
    logic                    pend_flag;

    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    upper_zero;
    logic                    suppress;
    logic                    lit;
    logic [6:0]              cur_seg;
    logic [NUM_DIGITS-1:0]   an_onehot;

    logic [6:0]              seg_p1;
    logic                    dp_p1;
    logic [NUM_DIGITS-1:0]   an_p1;

    // ---- stage p0: slot counter, digit index and slot FSM ----
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_p0   <= '0;
            idx_p0   <= '0;
            state_p0 <= RESET_STATE;
        end else begin
            cnt_p0   <= cnt_next;
            idx_p0   <= idx_next;
            state_p0 <= state_next;
        end
    end

    always_comb begin
        cnt_next = cnt_p0 + CNT_W'(1);
        idx_next = idx_p0;
        if (cnt_p0 == CNT_LAST) begin
            cnt_next = '0;
            idx_next = (idx_p0 == IDX_LAST) ? '0 : idx_p0 + IDX_W'(1);
        end
        state_next = (cnt_next < CNT_GUARD) ? GUARD : ON;
    end

    assign frame_end = (cnt_p0 == CNT_LAST) && (idx_p0 == IDX_LAST);

    // Data arriving on the frame-end cycle bypasses the pending buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_data <= '0;
            pend_dp   <= '0;
            disp_data <= '0;
            disp_dp   <= '0;
            pend_flag <= 1'b0;
        end else if (frame_end && valid_in) begin
            disp_data <= data_in;
            disp_dp   <= dp_in;
            pend_flag <= 1'b0;
        end else if (frame_end && pend_flag) begin
            disp_data <= pend_data;
            disp_dp   <= pend_dp;
            pend_flag <= 1'b0;
        end else if (valid_in) begin
            pend_data <= data_in;
            pend_dp   <= dp_in;
            pend_flag <= 1'b1;
        end
    end

    assign commit_out = !reset && frame_end && (valid_in || pend_flag);

    always_comb begin
        cur_nib    = '0;
        cur_dp     = 1'b0;
        upper_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (IDX_W'(k) == idx_p0) begin
                cur_nib = disp_data[4*k +: 4];
                cur_dp  = disp_dp[k];
            end
            if ((k >= int'(idx_p0)) && (disp_data[4*k +: 4] != 4'd0))
                upper_zero = 1'b0;
        end
        suppress = LZ_SUPPRESS && (idx_p0 != '0) && upper_zero && !cur_dp;
        lit      = (state_p0 == ON) && !blank_in && !suppress;
    end

    seg7_hex_lut u_hex_lut (
        .nibble (cur_nib),
        .seg    (cur_seg)
    );

    assign an_onehot = NUM_DIGITS'(1) << idx_p0;

    // ---- stage p1: registered pin drivers ----
    always_ff @(posedge clk) begin
        if (reset) begin
            an_p1  <= AN_OFF;
            seg_p1 <= SEG_OFF;
            dp_p1  <= DP_OFF;
        end else if (lit) begin
            an_p1  <= AN_ACTIVE_LOW ? ~an_onehot : an_onehot;
            seg_p1 <= SEG_ACTIVE_LOW ? cur_seg : ~cur_seg;
            dp_p1  <= SEG_ACTIVE_LOW ? ~cur_dp : cur_dp;
        end else begin
            an_p1  <= AN_OFF;
            seg_p1 <= SEG_OFF;
            dp_p1  <= DP_OFF;
        end
    end

    assign anode_out    = an_p1;
    assign segments_out = seg_p1;
    assign dp_out       = dp_p1;

endmodule

// File: tb/tb_seg7_mux_display.sv
// Self-checking bench for seg7_mux_display: scenario tasks plus a cycle-count based reference model.
module tb_seg7_mux_display;

    localparam int N  = 4;
    localparam int R  = 8;
    localparam int G  = 2;
    localparam int FR = N * R;

    logic           clk;
    logic           reset;
    logic [4*N-1:0] data_in;
    logic           valid_in;
    logic [N-1:0]   dp_in;
    logic           blank_in;
    logic [6:0]     segments_out;
    logic           dp_out;
    logic [N-1:0]   anode_out;
    logic           commit_out;

    int checks   = 0;
    int failures = 0;

    seg7_mux_display #(
        .NUM_DIGITS     (N),
        .REFRESH_DIV    (R),
        .GUARD_CYCLES   (G),
        .LZ_SUPPRESS    (1'b1),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .dp_in        (dp_in),
        .blank_in     (blank_in),
        .segments_out (segments_out),
        .dp_out       (dp_out),
        .anode_out    (anode_out),
        .commit_out   (commit_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: position in the scan is derived from the number of cycles since reset.
    int             m_n = 0;
    logic [4*N-1:0] m_disp, m_pbuf;
    logic [N-1:0]   m_ddp, m_pdp;
    logic           m_pend;
    logic [N-1:0]   m_an;
    logic [6:0]     m_seg;
    logic           m_dp;
    logic           m_commit;

    function automatic logic [6:0] ref_seg(input logic [3:0] h);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
              7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[h];
    endfunction

    function automatic logic lit_of(input int n, input logic [4*N-1:0] d, input logic [N-1:0] p, input logic b);
        int dg;
        dg = (n / R) % N;
        if ((n % R) < G || b) return 1'b0;
        if (dg > 0 && (d >> (4*dg)) == '0 && p[dg] == 1'b0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [N-1:0] exp_an(input int n, input logic [4*N-1:0] d, input logic [N-1:0] p, input logic b);
        logic [N-1:0] one;
        one = 1;
        return lit_of(n, d, p, b) ? ~(one << ((n / R) % N)) : {N{1'b1}};
    endfunction

    function automatic logic [6:0] exp_seg(input int n, input logic [4*N-1:0] d, input logic [N-1:0] p, input logic b);
        return lit_of(n, d, p, b) ? ref_seg(4'(d >> (4*((n / R) % N)))) : 7'b1111111;
    endfunction

    function automatic logic exp_dp(input int n, input logic [4*N-1:0] d, input logic [N-1:0] p, input logic b);
        return lit_of(n, d, p, b) ? ~p[(n / R) % N] : 1'b1;
    endfunction

    assign m_commit = !reset && ((m_n % FR) == FR - 1) && (m_pend || valid_in);

    always @(posedge clk) begin
        if (reset) begin
            m_n    <= 0;
            m_disp <= '0;
            m_ddp  <= '0;
            m_pbuf <= '0;
            m_pdp  <= '0;
            m_pend <= 1'b0;
            m_an   <= {N{1'b1}};
            m_seg  <= 7'b1111111;
            m_dp   <= 1'b1;
        end else begin
            m_an  <= exp_an(m_n, m_disp, m_ddp, blank_in);
            m_seg <= exp_seg(m_n, m_disp, m_ddp, blank_in);
            m_dp  <= exp_dp(m_n, m_disp, m_ddp, blank_in);
            if ((m_n % FR) == FR - 1 && valid_in) begin
                m_disp <= data_in;
                m_ddp  <= dp_in;
                m_pend <= 1'b0;
            end else if ((m_n % FR) == FR - 1 && m_pend) begin
                m_disp <= m_pbuf;
                m_ddp  <= m_pdp;
                m_pend <= 1'b0;
            end else if (valid_in) begin
                m_pbuf <= data_in;
                m_pdp  <= dp_in;
                m_pend <= 1'b1;
            end
            m_n <= m_n + 1;
        end
    end

    task automatic idle_to(input int ph);
        for (int i = 0; i < FR + 1 && (m_n % FR) != ph; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; valid_in = 1'b0; blank_in = 1'b0; data_in = '0; dp_in = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (anode_out !== 4'b1111 || segments_out !== 7'b1111111 || dp_out !== 1'b1 || commit_out !== 1'b0) begin
                failures++;
                $display("FAIL reset_state cyc=%0d got an=%b seg=%b dp=%b cm=%b want an=1111 seg=1111111 dp=1 cm=0",
                         i, anode_out, segments_out, dp_out, commit_out);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if ({anode_out, segments_out, dp_out, commit_out} !== {m_an, m_seg, m_dp, m_commit}) begin
                failures++;
                $display("FAIL reset_model n=%0d got %b_%b_%b_%b want %b_%b_%b_%b", m_n,
                         anode_out, segments_out, dp_out, commit_out, m_an, m_seg, m_dp, m_commit);
            end
            if (i == 2) begin
                checks++;
                if ({anode_out, segments_out} !== {4'b1110, 7'b1000000}) begin
                    failures++;
                    $display("FAIL first_on got an=%b seg=%b want an=1110 seg=1000000", anode_out, segments_out);
                end
            end
        end
    endtask

    task automatic test_commit_mid_frame();
        int commits = 0;
        int since = -1;
        logic [6:0] seen [N];
        logic [6:0] want [N];
        want = '{7'b1000000, 7'b0001000, 7'b0100100, 7'b1111001};
        for (int k = 0; k < N; k++) seen[k] = 'x;
        idle_to(10);
        valid_in = 1'b1; data_in = 16'h12A0; dp_in = '0;
        for (int i = 0; i < 3*FR && since < FR + 2; i++) begin
            @(negedge clk);
            checks++;
            if ({anode_out, segments_out, dp_out, commit_out} !== {m_an, m_seg, m_dp, m_commit}) begin
                failures++;
                $display("FAIL mid_model n=%0d got %b_%b_%b_%b want %b_%b_%b_%b", m_n,
                         anode_out, segments_out, dp_out, commit_out, m_an, m_seg, m_dp, m_commit);
            end
            if (since >= 0) since++;
            if (commit_out === 1'b1) begin commits++; if (since < 0) since = 0; end
            for (int k = 0; k < N; k++)
                if (since >= 2 && anode_out === ~(4'b0001 << k)) seen[k] = segments_out;
            valid_in = 1'b0;
        end
        checks++;
        if (commits != 1) begin
            failures++;
            $display("FAIL mid_commit_count got %0d want 1", commits);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (seen[k] !== want[k]) begin
                failures++;
                $display("FAIL mid_digit%0d got %b want %b", k, seen[k], want[k]);
            end
        end
    endtask

    task automatic test_lz();
        int since = -1;
        int upper_lit = 0;
        logic [6:0] d0 = 'x;
        idle_to(5);
        valid_in = 1'b1; data_in = 16'h0005; dp_in = '0;
        for (int i = 0; i < 3*FR && since < FR + 2; i++) begin
            @(negedge clk);
            checks++;
            if ({anode_out, segments_out, dp_out, commit_out} !== {m_an, m_seg, m_dp, m_commit}) begin
                failures++;
                $display("FAIL lz_model n=%0d got %b_%b_%b_%b want %b_%b_%b_%b", m_n,
                         anode_out, segments_out, dp_out, commit_out, m_an, m_seg, m_dp, m_commit);
            end
            if (since >= 0) since++;
            if (commit_out === 1'b1 && since < 0) since = 0;
            if (since >= 2) begin
                if (anode_out === 4'b1110) d0 = segments_out;
                else if (anode_out !== 4'b1111 || segments_out !== 7'b1111111) upper_lit++;
            end
            valid_in = 1'b0;
        end
        checks++;
        if (d0 !== 7'b0010010) begin
            failures++;
            $display("FAIL lz_digit0 got %b want 0010010", d0);
        end
        checks++;
        if (upper_lit != 0) begin
            failures++;
            $display("FAIL lz_upper_dark got %0d lit cycles want 0", upper_lit);
        end
    endtask

    task automatic test_back_to_back();
        int commits = 0;
        int since = -1;
        logic [6:0] seen [N];
        for (int k = 0; k < N; k++) seen[k] = 'x;
        idle_to(3);
        valid_in = 1'b1; data_in = 16'h1111; dp_in = '0;
        for (int i = 0; i < 3*FR && since < FR + 2; i++) begin
            @(negedge clk);
            checks++;
            if ({anode_out, segments_out, dp_out, commit_out} !== {m_an, m_seg, m_dp, m_commit}) begin
                failures++;
                $display("FAIL b2b_model n=%0d got %b_%b_%b_%b want %b_%b_%b_%b", m_n,
                         anode_out, segments_out, dp_out, commit_out, m_an, m_seg, m_dp, m_commit);
            end
            if (since >= 0) since++;
            if (commit_out === 1'b1) begin commits++; if (since < 0) since = 0; end
            for (int k = 0; k < N; k++)
                if (since >= 2 && anode_out === ~(4'b0001 << k)) seen[k] = segments_out;
            valid_in = (i == 8);
            data_in  = 16'h2222;
        end
        checks++;
        if (commits != 1) begin
            failures++;
            $display("FAIL b2b_commit_count got %0d want 1", commits);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (seen[k] !== 7'b0100100) begin
                failures++;
                $display("FAIL b2b_digit%0d got %b want 0100100", k, seen[k]);
            end
        end
    endtask

    task automatic test_frame_end_bypass();
        int since = 0;
        int extra = 0;
        int d3_lit = 0;
        logic [6:0] d2 = 'x;
        logic [6:0] d0 = 'x;
        idle_to(FR - 1);
        valid_in = 1'b1; data_in = 16'h0F00; dp_in = '0;
        #1;
        checks++;
        if (commit_out !== 1'b1 || m_commit !== 1'b1) begin
            failures++;
            $display("FAIL bypass_pulse got %b want 1 (model %b)", commit_out, m_commit);
        end
        for (int i = 0; i < FR + 2; i++) begin
            @(negedge clk);
            checks++;
            if ({anode_out, segments_out, dp_out, commit_out} !== {m_an, m_seg, m_dp, m_commit}) begin
                failures++;
                $display("FAIL bypass_model n=%0d got %b_%b_%b_%b want %b_%b_%b_%b", m_n,
                         anode_out, segments_out, dp_out, commit_out, m_an, m_seg, m_dp, m_commit);
            end
            since++;
            if (commit_out === 1'b1) extra++;
            if (since >= 2) begin
                if (anode_out === 4'b1011) d2 = segments_out;
                if (anode_out === 4'b1110) d0 = segments_out;
                if (anode_out === 4'b0111) d3_lit++;
            end
            valid_in = 1'b0;
        end
        checks++;
        if (d2 !== 7'b0001110) begin
            failures++;
            $display("FAIL bypass_digit2 got %b want 0001110", d2);
        end
        checks++;
        if (d0 !== 7'b1000000) begin
            failures++;
            $display("FAIL bypass_digit0 got %b want 1000000", d0);
        end
        checks++;
        if (d3_lit != 0 || extra != 0) begin
            failures++;
            $display("FAIL bypass_digit3_extra got lit=%0d commits=%0d want 0 0", d3_lit, extra);
        end
    endtask

    task automatic test_blank();
        int dark_fail = 0;
        idle_to(0);
        blank_in = 1'b1;
        for (int i = 0; i < 2*FR; i++) begin
            @(negedge clk);
            checks++;
            if ({anode_out, segments_out, dp_out, commit_out} !== {m_an, m_seg, m_dp, m_commit}) begin
                failures++;
                $display("FAIL blank_model n=%0d got %b_%b_%b_%b want %b_%b_%b_%b", m_n,
                         anode_out, segments_out, dp_out, commit_out, m_an, m_seg, m_dp, m_commit);
            end
            if (i < FR && anode_out !== 4'b1111) dark_fail++;
            if (i == FR - 2) begin
                checks++;
                if (commit_out !== 1'b1) begin
                    failures++;
                    $display("FAIL blank_commit_timing got %b want 1", commit_out);
                end
            end
            valid_in = (i == 3);
            data_in  = 16'h3456;
            if (i == FR - 1) blank_in = 1'b0;
        end
        checks++;
        if (dark_fail != 0) begin
            failures++;
            $display("FAIL blank_dark got %0d lit cycles want 0", dark_fail);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            checks++;
            if ({anode_out, segments_out, dp_out, commit_out} !== {m_an, m_seg, m_dp, m_commit}) begin
                failures++;
                $display("FAIL rand_model n=%0d got %b_%b_%b_%b want %b_%b_%b_%b", m_n,
                         anode_out, segments_out, dp_out, commit_out, m_an, m_seg, m_dp, m_commit);
            end
            valid_in = ($urandom_range(0, 7) == 0);
            data_in  = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            dp_in    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 15) == 0) blank_in = ~blank_in;
            reset    = (i >= 200 && i < 202);
        end
        reset = 1'b0; valid_in = 1'b0; blank_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_commit_mid_frame();
        test_lz();
        test_back_to_back();
        test_frame_end_bypass();
        test_blank();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
